vector_unpack_serial: RTL and testbench

- Sequential inverse of the team's lane-concatenation logic.
- Accepts one packed word of NUM_LANES lanes, each LANE_W bits wide, over a valid/ready handshake.
- Emits the lanes one per transfer, lane 0 (LSBs) first, on a registered valid/ready output with lane index and last flag.
- Sits between a packed-vector producer and a narrow lane-serial consumer.

---
 rtl/vector_unpack_serial_if.sv | 40 ++++
 rtl/vector_unpack_serial.sv | 108 ++++++++++
 tb/tb_vector_unpack_serial.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/vector_unpack_serial_if.sv
// Handshake bundle for vector_unpack_serial: packed-word input channel and lane-serial output.
// The slave modport is the unpacker; the master modport is the producer/consumer pair around it.
interface vector_unpack_serial_if #(
   parameter int unsigned LANE_W    = 4,
   parameter int unsigned NUM_LANES = 3
);
   localparam int unsigned IDX_W  = $clog2(NUM_LANES);
   localparam int unsigned DATA_W = NUM_LANES * LANE_W;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [LANE_W-1:0] out_data;
   logic [IDX_W-1:0]  out_lane;
   logic              out_last;

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_lane,
      output out_last
   );

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_lane,
      input  out_last
   );
endinterface

// File: rtl/vector_unpack_serial.sv
// Serialises one packed word of NUM_LANES lanes into a lane-per-transfer stream, lane 0 first,
// with registered valid/data/lane/last and a zero-bubble reload on the last-lane fire.
module vector_unpack_serial #(
   parameter int unsigned LANE_W    = 4,
   parameter int unsigned NUM_LANES = 3
) (
   input logic                   clk,
   input logic                   rst_n,
   input logic                   clr,
   vector_unpack_serial_if.slave bus
);
   localparam int unsigned IDX_W     = $clog2(NUM_LANES);
   localparam int unsigned DATA_W    = NUM_LANES * LANE_W;
   localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(NUM_LANES - 1);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              out_valid_q, out_valid_d;
   logic [LANE_W-1:0] out_data_q, out_data_d;
   logic [IDX_W-1:0]  out_lane_q, out_lane_d;
   logic              out_last_q, out_last_d;

   logic             in_ready;
   logic             accept;
   logic             fire;
   logic [IDX_W-1:0] lane_inc;

   assign fire     = out_valid_q & bus.out_ready;
   // Ready on the last-lane fire lets the next word load with no bubble.
   assign in_ready = ~clr & ((state_q == StIdle) | (fire & out_last_q));
   assign accept   = bus.in_valid & in_ready;
   assign lane_inc = out_lane_q + IDX_W'(1);

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_lane_d  = out_lane_q;
      out_last_d  = out_last_q;

      if (clr) begin
         state_d     = StIdle;
         out_valid_d = 1'b0;
         out_lane_d  = '0;
         out_last_d  = 1'b0;
      end else begin
         if (fire) begin
            if (out_last_q) begin
               // Data and lane index keep their final values after the word completes.
               state_d     = StIdle;
               out_valid_d = 1'b0;
            end else begin
               out_data_d = hold_q[LANE_W-1:0];
               hold_d     = hold_q >> LANE_W;
               out_lane_d = lane_inc;
               out_last_d = (lane_inc == LAST_LANE);
            end
         end
         if (accept) begin
            state_d     = StSend;
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data[LANE_W-1:0];
            hold_d      = bus.in_data >> LANE_W;
            out_lane_d  = '0;
            out_last_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         hold_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_lane_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_lane_q  <= out_lane_d;
         out_last_q  <= out_last_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_lane  = out_lane_q;
   assign bus.out_last  = out_last_q;

`ifndef SYNTHESIS
   a_valid_in_send: assert property (@(posedge clk) disable iff (!rst_n)
      out_valid_q |-> (state_q == StSend));
   a_lane_range: assert property (@(posedge clk) disable iff (!rst_n)
      out_valid_q |-> (out_lane_q <= LAST_LANE));
   a_last_match: assert property (@(posedge clk) disable iff (!rst_n)
      out_valid_q |-> (out_last_q == (out_lane_q == LAST_LANE)));
   a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid_q && !bus.out_ready && !clr) |=>
      (out_valid_q && $stable(out_data_q) && $stable(out_lane_q)));
`endif
endmodule

// File: tb/tb_vector_unpack_serial.sv
// Self-checking bench for vector_unpack_serial: directed scenarios plus a randomized run
// scored against a queue of expected lanes split from each accepted word.
module tb_vector_unpack_serial;
   localparam int unsigned LANE_W    = 4;
   localparam int unsigned NUM_LANES = 3;
   localparam int unsigned DATA_W    = NUM_LANES * LANE_W;
   localparam int unsigned IDX_W     = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic clr   = 1'b0;

   always #5 clk = ~clk;

   vector_unpack_serial_if #(.LANE_W(LANE_W), .NUM_LANES(NUM_LANES)) bus ();

   vector_unpack_serial #(
      .LANE_W    (LANE_W),
      .NUM_LANES (NUM_LANES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int words_in = 0;

   int exp_data_q[$];
   int exp_lane_q[$];

   logic              obs_valid, obs_ready, obs_last;
   logic [LANE_W-1:0] obs_data;
   logic [IDX_W-1:0]  obs_lane;

   bit                prev_stall = 1'b0;
   logic [LANE_W-1:0] prev_data;
   logic [IDX_W-1:0]  prev_lane;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive after the edge, sample at the falling edge, score against the lane queue.
   task automatic cycle(input logic iv, input logic [DATA_W-1:0] d, input logic ordy,
                        input logic c);
      bit exp_ready;
      @(posedge clk);
      #1;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      clr           = c;
      @(negedge clk);
      obs_valid = bus.out_valid;
      obs_ready = bus.in_ready;
      obs_data  = bus.out_data;
      obs_lane  = bus.out_lane;
      obs_last  = bus.out_last;

      check_eq("out_valid", 32'(obs_valid), 32'(exp_data_q.size() != 0));
      if (prev_stall) begin
         check_eq("stall_data", 32'(obs_data), 32'(prev_data));
         check_eq("stall_lane", 32'(obs_lane), 32'(prev_lane));
      end
      exp_ready = !c && (exp_data_q.size() == 0 || (exp_data_q.size() == 1 && ordy));
      check_eq("in_ready", 32'(obs_ready), 32'(exp_ready));

      if (c) begin
         exp_data_q.delete();
         exp_lane_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (obs_valid && ordy && exp_data_q.size() != 0) begin
            check_eq("lane_data", 32'(obs_data), 32'(exp_data_q[0]));
            check_eq("lane_idx", 32'(obs_lane), 32'(exp_lane_q[0]));
            check_eq("lane_last", 32'(obs_last), 32'(exp_lane_q[0] == NUM_LANES - 1));
            void'(exp_data_q.pop_front());
            void'(exp_lane_q.pop_front());
         end
         prev_stall = obs_valid && !ordy;
         prev_data  = obs_data;
         prev_lane  = obs_lane;
         if (iv && exp_ready) begin
            words_in++;
            for (int k = 0; k < NUM_LANES; k++) begin
               exp_data_q.push_back((int'(d) >> (k * LANE_W)) & ((1 << LANE_W) - 1));
               exp_lane_q.push_back(k);
            end
         end
      end
   endtask

   initial begin
      logic [LANE_W-1:0] b2b_data [6];
      bit                b2b_rdy  [6];
      b2b_data = '{4'h3, 4'h2, 4'h1, 4'hD, 4'hE, 4'hF};
      b2b_rdy  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      // Power-on reset
      #1;
      check_eq("rst_valid", 32'(bus.out_valid), 0);
      check_eq("rst_data", 32'(bus.out_data), 0);
      check_eq("rst_lane", 32'(bus.out_lane), 0);
      check_eq("rst_last", 32'(bus.out_last), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, '0, 1'b0, 1'b0);
      check_eq("rst_in_ready", 32'(obs_ready), 1);

      // Asynchronous reset with lane 1 of 12'hA5C pending
      cycle(1'b1, 12'hA5C, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_eq("mid_lane0", 32'(obs_data), 32'hC);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", 32'(bus.out_valid), 0);
      check_eq("mid_rst_data", 32'(bus.out_data), 0);
      check_eq("mid_rst_lane", 32'(bus.out_lane), 0);
      exp_data_q.delete();
      exp_lane_q.delete();
      prev_stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
      check_eq("post_rst_ready", 32'(obs_ready), 1);

      // Single word, consumer always ready
      cycle(1'b1, 12'hA5C, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_eq("single_d0", 32'(obs_data), 32'hC);
      check_eq("single_l0", 32'(obs_lane), 0);
      check_eq("single_t0", 32'(obs_last), 0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_eq("single_d1", 32'(obs_data), 32'h5);
      check_eq("single_l1", 32'(obs_lane), 1);
      check_eq("single_t1", 32'(obs_last), 0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_eq("single_d2", 32'(obs_data), 32'hA);
      check_eq("single_l2", 32'(obs_lane), 2);
      check_eq("single_t2", 32'(obs_last), 1);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_eq("single_done", 32'(obs_valid), 0);

      // Backpressure at lane 1
      cycle(1'b1, 12'hA5C, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 12'h777, 1'b0, 1'b0);
         check_eq("bp_data", 32'(obs_data), 32'h5);
         check_eq("bp_lane", 32'(obs_lane), 1);
         check_eq("bp_in_ready", 32'(obs_ready), 0);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_eq("bp_after_data", 32'(obs_data), 32'hA);
      check_eq("bp_after_lane", 32'(obs_lane), 2);
      cycle(1'b0, '0, 1'b0, 1'b0);

      // Back-to-back words
      cycle(1'b1, 12'h123, 1'b1, 1'b0);
      check_eq("b2b_first_acc", 32'(obs_ready), 1);
      for (int i = 0; i < 6; i++) begin
         cycle(1'(i < 3), 12'hFED, 1'b1, 1'b0);
         check_eq("b2b_valid", 32'(obs_valid), 1);
         check_eq("b2b_data", 32'(obs_data), 32'(b2b_data[i]));
         check_eq("b2b_ready", 32'(obs_ready), 32'(b2b_rdy[i]));
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_eq("b2b_done", 32'(obs_valid), 0);

      // Synchronous clear during a stall
      cycle(1'b1, 12'h0B7, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_eq("clr_lane0", 32'(obs_data), 32'h7);
      cycle(1'b0, '0, 1'b0, 1'b0);
      check_eq("clr_pre_lane", 32'(obs_lane), 1);
      cycle(1'b1, 12'h3C9, 1'b0, 1'b1);
      check_eq("clr_in_ready", 32'(obs_ready), 0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      check_eq("clr_valid", 32'(obs_valid), 0);
      check_eq("clr_lane", 32'(obs_lane), 0);
      check_eq("clr_last", 32'(obs_last), 0);
      cycle(1'b1, 12'h3C9, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_eq("clr_new_d0", 32'(obs_data), 32'h9);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_eq("clr_new_d1", 32'(obs_data), 32'hC);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_eq("clr_new_d2", 32'(obs_data), 32'h3);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // Randomized traffic
      words_in = 0;
      for (int cyc = 0; cyc < 20000 && words_in < 1000; cyc++) begin
         cycle(1'($urandom_range(1, 0)), DATA_W'($urandom), 1'($urandom_range(1, 0)), 1'b0);
      end
      check_eq("rand_words", 32'(words_in), 1000);
      for (int i = 0; i < 10 && exp_data_q.size() != 0; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b0);
      end
      check_eq("rand_drained", 32'(exp_data_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
